// File: rtl/clock_timekeeper.sv
// Wall-clock timekeeper: samples a 1 Hz square wave as data, detects its rising
// edges and keeps packed-BCD hh:mm:ss with 12/24-hour modes and a manual set mode.
module clock_timekeeper #(
  parameter bit HOUR_24     = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk1hz,
  input  logic       set_en,
  input  logic       set_hour_inc,
  input  logic       set_min_inc,
  input  logic       clr_sec,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic [7:0] seconds_bcd,
  output logic       pm,
  output logic       tick,
  output logic       day_wrap
);

  localparam logic [7:0] HOUR_RST = HOUR_24 ? 8'h00 : 8'h12;
  localparam logic [7:0] HOUR_MAX = HOUR_24 ? 8'h23 : 8'h12;
  localparam logic [7:0] HOUR_MIN = HOUR_24 ? 8'h00 : 8'h01;

  // Increment a packed-BCD value, wrapping from max back to lo.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                         input logic [7:0] max,
                                         input logic [7:0] lo);
    if (v == max) return lo;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      tick   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk1hz};
      prev_q <= sync_q[SYNC_STAGES-1];
      tick   <= rise;
    end
  end

  logic       sec_top, min_top, hour_top, pm_flip, run_step;
  logic [7:0] sec_n, min_n, hour_n;
  logic       pm_n, wrap_n;

  assign sec_top  = (seconds_bcd == 8'h59);
  assign min_top  = (minutes_bcd == 8'h59);
  assign hour_top = HOUR_24 ? (hours_bcd == 8'h23) : ((hours_bcd == 8'h11) && pm);
  assign pm_flip  = !HOUR_24 && (hours_bcd == 8'h11);
  assign run_step = rise && !set_en;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    sec_n  = seconds_bcd;
    min_n  = minutes_bcd;
    hour_n = hours_bcd;
    pm_n   = pm;
    wrap_n = 1'b0;
    if (run_step) begin
      sec_n = bcd_inc(seconds_bcd, 8'h59, 8'h00);
      if (sec_top) begin
        min_n = bcd_inc(minutes_bcd, 8'h59, 8'h00);
        if (min_top) begin
          hour_n = bcd_inc(hours_bcd, HOUR_MAX, HOUR_MIN);
          pm_n   = pm ^ pm_flip;
          wrap_n = hour_top;
        end
      end
    end else if (set_en) begin
      // Set-mode pulses act independently and never carry between fields.
      if (set_min_inc) min_n = bcd_inc(minutes_bcd, 8'h59, 8'h00);
      if (set_hour_inc) begin
        hour_n = bcd_inc(hours_bcd, HOUR_MAX, HOUR_MIN);
        pm_n   = pm ^ pm_flip;
      end
      if (clr_sec) sec_n = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seconds_bcd <= 8'h00;
      minutes_bcd <= 8'h00;
      hours_bcd   <= HOUR_RST;
      pm          <= 1'b0;
      day_wrap    <= 1'b0;
    end else begin
      seconds_bcd <= sec_n;
      minutes_bcd <= min_n;
      hours_bcd   <= hour_n;
      pm          <= pm_n;
      day_wrap    <= wrap_n;
    end
  end

endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed bench: one 24-hour and one 12-hour timekeeper driven from shared
// stimulus, checked against hand-computed times.
module tb_clock_timekeeper;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk1hz = 1'b0;
  logic       set_en = 1'b0;
  logic       set_hour_inc = 1'b0;
  logic       set_min_inc = 1'b0;
  logic       clr_sec = 1'b0;

  logic [7:0] h24, m24, s24, h12, m12, s12;
  logic       pm24, tick24, dw24, pm12, tick12, dw12;

  clock_timekeeper #(.HOUR_24(1'b1), .SYNC_STAGES(2)) dut24 (
    .clk(clk), .rst(rst), .clk1hz(clk1hz), .set_en(set_en),
    .set_hour_inc(set_hour_inc), .set_min_inc(set_min_inc), .clr_sec(clr_sec),
    .hours_bcd(h24), .minutes_bcd(m24), .seconds_bcd(s24),
    .pm(pm24), .tick(tick24), .day_wrap(dw24)
  );

  clock_timekeeper #(.HOUR_24(1'b0), .SYNC_STAGES(2)) dut12 (
    .clk(clk), .rst(rst), .clk1hz(clk1hz), .set_en(set_en),
    .set_hour_inc(set_hour_inc), .set_min_inc(set_min_inc), .clr_sec(clr_sec),
    .hours_bcd(h12), .minutes_bcd(m12), .seconds_bcd(s12),
    .pm(pm12), .tick(tick12), .day_wrap(dw12)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int lat, nt24, nt12, ndw24, ndw12;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clk1hz period: high for hi cycles, low for lo cycles, sampled on negedges.
  task automatic run_period(input int hi, input int lo);
    lat = 0; nt24 = 0; nt12 = 0; ndw24 = 0; ndw12 = 0;
    clk1hz = 1'b1;
    for (int i = 1; i <= hi + lo; i++) begin
      @(negedge clk);
      if (tick24) begin
        nt24++;
        if (lat == 0) lat = i;
      end
      if (tick12) nt12++;
      if (dw24) ndw24++;
      if (dw12) ndw12++;
      if (i == hi) clk1hz = 1'b0;
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) run_period(20, 20);
  endtask

  task automatic pulse(input logic h, input logic m, input logic c, input int n);
    for (int i = 0; i < n; i++) begin
      set_hour_inc = h; set_min_inc = m; clr_sec = c;
      @(negedge clk);
      set_hour_inc = 1'b0; set_min_inc = 1'b0; clr_sec = 1'b0;
      @(negedge clk);
    end
  endtask

  function automatic logic [31:0] t24();
    return {8'h00, h24, m24, s24};
  endfunction

  function automatic logic [31:0] t12();
    return {7'h00, pm12, h12, m12, s12};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_t24"}, t24(), 32'h0000_0000);
    check({tag, "_t12"}, t12(), 32'h0012_0000);
    check({tag, "_flags"}, {28'h0, pm24, tick24, tick12, dw24 | dw12}, 32'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Run from reset: tick 3 cycles after each rise, one per period.
    for (int k = 1; k <= 3; k++) begin
      run_period(20, 20);
      check($sformatf("tick_lat%0d", k), lat, 3);
      check($sformatf("tick_cnt%0d", k), nt24 + nt12, 2);
      check($sformatf("sec%0d", k), {s24, s12}, {2{8'(k)}});
    end

    // Set mode: clear seconds, walk minutes to 59 then wrap without carry.
    set_en = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, 1);
    check("clr_sec", {s24, s12}, 16'h0000);
    pulse(1'b0, 1'b1, 1'b0, 59);
    check("min59", {h24, m24, h12, m12}, 32'h0059_1259);
    pulse(1'b0, 1'b1, 1'b0, 1);
    check("min_wrap", {h24, m24, h12, m12, 7'h0, pm12}, 40'h0000_1200_00);

    // Ticks in set mode pulse but do not advance seconds.
    for (int k = 0; k < 5; k++) begin
      run_period(20, 20);
      check($sformatf("set_tick%0d", k), {nt24[7:0], ndw24[7:0] | ndw12[7:0]}, 16'h0100);
    end
    check("set_sec_hold", {s24, s12}, 16'h0000);

    pulse(1'b1, 1'b1, 1'b0, 1);
    check("both_inc", {h24, m24, h12, m12, 7'h0, pm12}, 40'h0101_0101_00);

    pulse(1'b0, 1'b1, 1'b0, 58);
    pulse(1'b1, 1'b0, 1'b0, 11);
    check("set_noon", {h24, h12, 7'h0, pm12}, 24'h1212_01);
    pulse(1'b1, 1'b0, 1'b0, 11);
    check("set_late24", t24(), 32'h0023_5900);
    check("set_late12", t12(), 32'h0111_5900);

    // Run to midnight.
    set_en = 1'b0;
    run_ticks(58);
    check("pre_mid24", t24(), 32'h0023_5958);
    run_period(20, 20);
    check("t235959", t24(), 32'h0023_5959);
    check("no_wrap59", ndw24 + ndw12, 0);
    run_period(20, 20);
    check("mid24", t24(), 32'h0000_0000);
    check("mid12", t12(), 32'h0012_0000);
    check("day_wrap", {ndw24[7:0], ndw12[7:0]}, 16'h0101);

    // 11:59:59 AM -> 12:00:00 PM, no day_wrap.
    set_en = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 11);
    pulse(1'b0, 1'b1, 1'b0, 59);
    set_en = 1'b0;
    run_ticks(59);
    check("am_end24", t24(), 32'h0011_5959);
    check("am_end12", t12(), 32'h0011_5959);
    run_period(20, 20);
    check("noon24", t24(), 32'h0012_0000);
    check("noon12", t12(), 32'h0112_0000);
    check("noon_nowrap", ndw24 + ndw12, 0);

    // Long high level gives exactly one tick.
    run_period(1000, 20);
    check("long_high", {nt24[7:0], nt12[7:0]}, 16'h0101);
    check("long_sec", {s24, s12}, 16'h0101);

    // Preset 14:37:22 (02:37:22 PM).
    set_en = 1'b1;
    pulse(1'b0, 1'b0, 1'b1, 1);
    pulse(1'b1, 1'b0, 1'b0, 2);
    pulse(1'b0, 1'b1, 1'b0, 37);
    set_en = 1'b0;
    run_ticks(22);
    check("t143722_24", t24(), 32'h0014_3722);
    check("t143722_12", t12(), 32'h0102_3722);
    pulse(1'b1, 1'b1, 1'b1, 1);
    check("run_ignore", t24(), 32'h0014_3722);

    // Reset lands on the edge that would have raised tick.
    clk1hz = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset("mid_rst");
    clk1hz = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clock_timekeeper.md
Name: clock_timekeeper

Overview:
- Consumes the slow 1 Hz square wave from the divider and keeps wall-clock time as packed BCD hours, minutes and seconds. The time is read by the display/segment-mux logic.
- The 1 Hz signal is treated as data, not as a clock. It is synchronised into the system clock domain and rising-edge detected there.
- A set mode supports manual time entry from debounced button pulses.

Parameters:
- HOUR_24, 1, 1 selects 24-hour mode (00–23); 0 selects 12-hour mode (12, 01–11) with an AM/PM flag.
- SYNC_STAGES, 2, number of synchroniser flops on clk1hz; legal range 2–4.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous reset, active-high.
- clk1hz  input  1  1 Hz square wave from the divider; asynchronous to the logic's sampling assumptions.
- set_en  input  1  high selects set mode; seconds counting is suspended.
- set_hour_inc  input  1  one-cycle pulse; increments hours while in set mode.
- set_min_inc  input  1  one-cycle pulse; increments minutes while in set mode.
- clr_sec  input  1  one-cycle pulse; zeroes seconds while in set mode.
- hours_bcd  output  8  [7:4] tens digit, [3:0] ones digit.
- minutes_bcd  output  8  [7:4] tens digit, [3:0] ones digit.
- seconds_bcd  output  8  [7:4] tens digit, [3:0] ones digit.
- pm  output  1  PM flag in 12-hour mode; constant 0 in 24-hour mode.
- tick  output  1  one-cycle pulse per detected clk1hz rising edge.
- day_wrap  output  1  one-cycle pulse when time rolls over to midnight.

Behaviour:
- **Clock and reset:** single clock, clk. Reset is synchronous and active-high on rst.
- **Reset values:**
  - Synchroniser and edge register: all 0.
  - tick = 0, day_wrap = 0.
  - seconds_bcd = 0x00, minutes_bcd = 0x00.
  - hours_bcd = 0x00 when HOUR_24 = 1; 0x12 when HOUR_24 = 0.
  - pm = 0.
  - Reset overrides every other input in the same cycle.
- **Edge detection:**
  - clk1hz passes through SYNC_STAGES flops, then one more "previous" flop.
  - A rise is detected when the last sync stage is 1 and the previous flop is 0.
  - tick is registered. It goes high at the 3rd clk edge after the first edge that samples clk1hz high (SYNC_STAGES = 2); each extra stage adds one cycle.
  - tick is high for exactly 1 cycle per clk1hz rise, however long clk1hz stays high. clk1hz falling edges are ignored.
- **Run mode (set_en = 0):**
  - Time advances on the same clk edge that raises tick, so outputs change in the same cycle tick is high.
  - Seconds count 00..59; 59 → 00 carries into minutes.
  - Minutes count 00..59; 59 → 00 carries into hours.
  - Hours, 24-hour mode: 23 → 00 and day_wrap pulses.
  - Hours, 12-hour mode: 11 → 12 toggles pm; 12 → 01; day_wrap pulses on the 11:59:59 PM → 12:00:00 AM transition.
  - All carries resolve within the single update. Every BCD digit stays legal at all times (ones 0–9, tens within range).
  - set_hour_inc, set_min_inc and clr_sec are ignored.
- **Set mode (set_en = 1):**
  - tick still pulses; seconds do not advance; day_wrap never pulses.
  - set_min_inc: minutes +1, wrapping 59 → 00 with no carry into hours.
  - set_hour_inc: hours +1, same wrap rules as run mode (including the 12-hour pm toggle at 11 → 12), with no day_wrap.
  - clr_sec: seconds ← 00.
  - Simultaneous pulses all take effect in the same cycle, independently.
- **Set-mode exit:** counting resumes on the next tick after set_en falls. A tick coincident with the cycle set_en falls is governed by the set_en value sampled on that edge.
- **Illegal BCD:** impossible from reset, so no recovery logic is required.

Test Plan:
- Reset, then toggle clk1hz with a period of 40 clk → tick pulses once every 40 cycles, exactly 3 cycles after each clk1hz rise; seconds go 00, 01, 02.
- HOUR_24 = 1, preset to 23:59:58 via set mode, then run 2 ticks → 23:59:59, then 00:00:00 with day_wrap high for that single cycle.
- HOUR_24 = 0, preset to 11:59:59 AM, 1 tick → 12:00:00, pm = 1, no day_wrap; at 11:59:59 PM, 1 tick → 12:00:00, pm = 0, day_wrap = 1.
- set_en = 1 with minutes = 59, pulse set_min_inc → minutes 00, hours unchanged; 5 ticks → seconds unchanged; pulse set_min_inc and set_hour_inc together → both increment.
- Hold clk1hz high for 1000 cycles → exactly one tick; assert rst mid-count at 14:37:22 → next cycle all outputs at reset values, tick = 0.
